deserializer: RTL and testbench

//   Receive-side partner of the serializer stage.

---
 rtl/deserializer.sv | 129 ++++++++++++
 tb/tb_deserializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: assembles LSB-first bits into WIDTH-bit words
// and buffers completed words in a small FIFO with a valid/ready output.
module deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_input,
    input  logic             ser_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] par_output,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             overrun_q, overrun_d;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [WIDTH-1:0] word_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign word_s  = {ser_input, shreg_q[WIDTH-1:1]};

    assign par_valid  = !empty_s;
    assign par_output = empty_s ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign busy       = (state_q == RECV);
    assign overrun    = overrun_q;

    // Bit assembly: count, shift register and receive state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        push_s  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            shreg_d = '0;
        end else if (ser_valid) begin
            shreg_d = word_s;
            if (count_q == CW'(WIDTH - 1)) begin
                count_d = '0;
                state_d = IDLE;
                push_s  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
                state_d = RECV;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Output FIFO: a push into a full FIFO only lands if the head pops on the same edge.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;
        overrun_d = overrun_q;
        pop_s     = !empty_s && par_ready && !clear;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            overrun_d = 1'b0;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && (!full_s || pop_s)) begin
                mem_d[wr_ptr_q[AW-1:0]] = word_s;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else if (push_s) begin
                overrun_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shreg_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_deserializer;

    localparam int W = 8;
    localparam int D = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ser_input = 1'b0;
    logic         ser_valid = 1'b0;
    logic         clear = 1'b0;
    logic         par_ready = 1'b0;
    logic [W-1:0] par_output;
    logic         par_valid;
    logic         busy;
    logic         overrun;

    deserializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .ser_input  (ser_input),
        .ser_valid  (ser_valid),
        .clear      (clear),
        .par_output (par_output),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int           vectors = 0;
    int           miscompares = 0;

    // Reference model state
    int           m_cnt = 0;
    logic [W-1:0] m_part = '0;
    logic [W-1:0] m_q[$];
    logic         m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_part = '0;
        m_q.delete();
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge();
        bit pop;
        bit was_full;
        if (clear) begin
            model_reset();
        end else begin
            pop      = (m_q.size() > 0) && par_ready;
            was_full = (m_q.size() == D);
            if (pop) void'(m_q.pop_front());
            if (ser_valid) begin
                m_part[m_cnt] = ser_input;
                m_cnt++;
                if (m_cnt == W) begin
                    if (was_full && !pop) m_ovr = 1'b1;
                    else m_q.push_back(m_part);
                    m_part = '0;
                    m_cnt  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("par_valid", 32'(par_valid), 32'(m_q.size() > 0));
        chk("par_output", 32'(par_output), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // One clock: inputs already driven, model advances with the edge, then compare.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            ser_input = w[i];
            ser_valid = 1'b1;
            step();
            if (gap) begin
                ser_valid = 1'b0;
                ser_input = ~ser_input;
                step();
            end
        end
        ser_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #12;
        model_reset();
        check_all();
        reset = 1'b0;

        // Test 1: 0xA5 back-to-back with ready high
        par_ready = 1'b1;
        send_bits(8'hA5, 0, W - 1, 1'b0);
        chk("t1_word", 32'(par_output), 32'h0000_00A5);
        chk("t1_valid", 32'(par_valid), 32'd1);
        step();
        chk("t1_pulse_end", 32'(par_valid), 32'd0);

        // Test 2: 0x3C with a gap after every bit
        send_bits(8'h3C, 0, W - 1, 1'b1);

        // Test 3: ready low, three words overflow the two-entry FIFO
        ser_valid = 1'b0;
        par_ready = 1'b0;
        step();
        send_bits(8'h11, 0, W - 1, 1'b0);
        send_bits(8'h22, 0, W - 1, 1'b0);
        send_bits(8'h33, 0, W - 1, 1'b0);
        chk("t3_head", 32'(par_output), 32'h0000_0011);
        chk("t3_ovr", 32'(overrun), 32'd1);
        par_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t3_drained", 32'(par_valid), 32'd0);

        // Test 4: full FIFO with pop on the completing edge
        do_clear();
        par_ready = 1'b0;
        send_bits(8'h11, 0, W - 1, 1'b0);
        send_bits(8'h22, 0, W - 1, 1'b0);
        send_bits(8'h44, 0, W - 2, 1'b0);
        par_ready = 1'b1;
        send_bits(8'h44, W - 1, W - 1, 1'b0);
        chk("t4_ovr", 32'(overrun), 32'd0);
        chk("t4_head", 32'(par_output), 32'h0000_0022);
        for (int i = 0; i < 3; i++) step();

        // Test 5: partial word flushed by clear
        send_bits(8'hFF, 0, 4, 1'b0);
        do_clear();
        chk("t5_busy", 32'(busy), 32'd0);
        par_ready = 1'b0;
        send_bits(8'h5A, 0, W - 1, 1'b0);
        chk("t5_word", 32'(par_output), 32'h0000_005A);
        chk("t5_ovr", 32'(overrun), 32'd0);

        // Test 6: async reset mid-word with the FIFO occupied
        send_bits(8'h0F, 0, 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_out", 32'(par_output), 32'd0);
        #1;
        reset = 1'b0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            ser_valid = ($urandom_range(0, 3) != 0);
            ser_input = 1'($urandom);
            par_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 60) == 0);
            step();
        end
        clear     = 1'b0;
        ser_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
